alu_ctl_stage: RTL



---
 rtl/alu_pkg.sv | 39 +++
 rtl/alu_ctl_decode.sv | 41 ++++
 rtl/alu_ctl_stage.sv | 118 +++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU-control definitions: ALU codes, ALUOp encodings, LEGv8 opcode patterns.
package alu_pkg;

    // ALU operation codes consumed by the 64-bit ALU
    localparam logic [3:0] ALU_AND = 4'd0;
    localparam logic [3:0] ALU_OR  = 4'd1;
    localparam logic [3:0] ALU_ADD = 4'd2;
    localparam logic [3:0] ALU_SUB = 4'd6;
    localparam logic [3:0] ALU_SLT = 4'd7;   // defined for the ALU, never produced here
    localparam logic [3:0] ALU_NOR = 4'd12;  // defined for the ALU, never produced here
    localparam logic [3:0] ALU_ILL = 4'd15;  // ALU outputs zero for this code

    // ALUOp encodings from main control
    typedef enum logic [1:0] {
        ALUOP_MEM = 2'b00,
        ALUOP_CBZ = 2'b01,
        ALUOP_R   = 2'b10,
        ALUOP_I   = 2'b11
    } aluop_t;

    // R-type opcodes, full instruction[31:21]
    localparam logic [10:0] OP_ADD = 11'b10001011000;
    localparam logic [10:0] OP_SUB = 11'b11001011000;
    localparam logic [10:0] OP_AND = 11'b10001010000;
    localparam logic [10:0] OP_ORR = 11'b10101010000;

    // I-type opcodes, matched on instruction[31:22] only
    localparam logic [9:0] OP_ADDI = 10'b1001000100;
    localparam logic [9:0] OP_SUBI = 10'b1101000100;
    localparam logic [9:0] OP_ANDI = 10'b1001001000;
    localparam logic [9:0] OP_ORRI = 10'b1011001000;

    // One decoded entry as held in the main/skid registers
    typedef struct packed {
        logic [3:0] ctr;
        logic       ill;
    } ctl_entry_t;

endpackage

// File: rtl/alu_ctl_decode.sv
// Combinational ALU-control decode: (opcode, aluop) -> (alu_ctr, illegal).
// Shared with the single-cycle CPU, so it carries no state.
module alu_ctl_decode
    import alu_pkg::*;
(
    input  logic [10:0] opcode,
    input  logic [1:0]  aluop,
    output logic [3:0]  alu_ctr,
    output logic        illegal
);

    // Select the ALU code from ALUOp, falling back to the illegal code for unknown R/I opcodes
    always_comb begin
        alu_ctr = ALU_ILL;
        illegal = 1'b1;
        case (aluop)
            ALUOP_MEM: begin alu_ctr = ALU_ADD; illegal = 1'b0; end
            ALUOP_CBZ: begin alu_ctr = ALU_SUB; illegal = 1'b0; end
            ALUOP_R: begin
                case (opcode)
                    OP_ADD:  begin alu_ctr = ALU_ADD; illegal = 1'b0; end
                    OP_SUB:  begin alu_ctr = ALU_SUB; illegal = 1'b0; end
                    OP_AND:  begin alu_ctr = ALU_AND; illegal = 1'b0; end
                    OP_ORR:  begin alu_ctr = ALU_OR;  illegal = 1'b0; end
                    default: begin alu_ctr = ALU_ILL; illegal = 1'b1; end
                endcase
            end
            ALUOP_I: begin
                case (opcode[10:1])
                    OP_ADDI: begin alu_ctr = ALU_ADD; illegal = 1'b0; end
                    OP_SUBI: begin alu_ctr = ALU_SUB; illegal = 1'b0; end
                    OP_ANDI: begin alu_ctr = ALU_AND; illegal = 1'b0; end
                    OP_ORRI: begin alu_ctr = ALU_OR;  illegal = 1'b0; end
                    default: begin alu_ctr = ALU_ILL; illegal = 1'b1; end
                endcase
            end
            default: begin alu_ctr = ALU_ILL; illegal = 1'b1; end
        endcase
    end

endmodule

// File: rtl/alu_ctl_stage.sv
// Registered ALU-control stage at the ID/EX boundary: decode on input, main register
// plus one skid entry for full throughput under back-pressure, flush on redirect and
// a saturating count of illegal entries delivered to EX.
module alu_ctl_stage
    import alu_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [10:0]      opcode,
    input  logic [1:0]       aluop,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       alu_ctr,
    output logic             illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam ctl_entry_t ENTRY_ZERO = '{ctr: 4'd0, ill: 1'b0};

    ctl_entry_t       dec_s;
    ctl_entry_t       main_r, main_n_s;
    ctl_entry_t       skid_r, skid_n_s;
    logic             main_v_r, main_v_n_s;
    logic             skid_v_r, skid_v_n_s;
    logic             in_ready_r;
    logic [CNT_W-1:0] cnt_r, cnt_n_s;
    logic             accept_s;
    logic             deliver_s;

    alu_ctl_decode u_decode (
        .opcode  (opcode),
        .aluop   (aluop),
        .alu_ctr (dec_s.ctr),
        .illegal (dec_s.ill)
    );

    assign accept_s  = in_valid && in_ready_r;
    assign deliver_s = main_v_r && out_ready;

    // Next state of main/skid: flush clears everything, otherwise keep FIFO order
    always_comb begin
        main_v_n_s = main_v_r;
        main_n_s   = main_r;
        skid_v_n_s = skid_v_r;
        skid_n_s   = skid_r;
        if (flush) begin
            main_v_n_s = 1'b0;
            main_n_s   = ENTRY_ZERO;
            skid_v_n_s = 1'b0;
            skid_n_s   = ENTRY_ZERO;
        end else if (!main_v_r || deliver_s) begin
            if (skid_v_r) begin
                // Older skid entry advances; a new entry takes its place behind it
                main_v_n_s = 1'b1;
                main_n_s   = skid_r;
                skid_v_n_s = accept_s;
                skid_n_s   = accept_s ? dec_s : skid_r;
            end else begin
                // Main empty or draining: new entry goes straight to main;
                // otherwise the last value stays visible on alu_ctr/illegal
                main_v_n_s = accept_s;
                main_n_s   = accept_s ? dec_s : main_r;
            end
        end else begin
            // Main stalled: an accepted entry parks in the skid slot, which is empty
            // whenever in_ready was high
            if (accept_s) begin
                skid_v_n_s = 1'b1;
                skid_n_s   = dec_s;
            end else begin
                skid_v_n_s = skid_v_r;
                skid_n_s   = skid_r;
            end
        end
    end

    // Illegal counter: counts deliveries of illegal entries, including on a flush cycle
    always_comb begin
        cnt_n_s = cnt_r;
        if (deliver_s && main_r.ill && (cnt_r != CNT_MAX)) begin
            cnt_n_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_n_s = cnt_r;
        end
    end

    // State registers with synchronous active-low reset; in_ready tracks the next skid state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_v_r   <= 1'b0;
            main_r     <= ENTRY_ZERO;
            skid_v_r   <= 1'b0;
            skid_r     <= ENTRY_ZERO;
            in_ready_r <= 1'b1;
            cnt_r      <= {CNT_W{1'b0}};
        end else begin
            main_v_r   <= main_v_n_s;
            main_r     <= main_n_s;
            skid_v_r   <= skid_v_n_s;
            skid_r     <= skid_n_s;
            in_ready_r <= !skid_v_n_s;
            cnt_r      <= cnt_n_s;
        end
    end

    assign in_ready    = in_ready_r;
    assign out_valid   = main_v_r;
    assign alu_ctr     = main_r.ctr;
    assign illegal     = main_r.ill;
    assign illegal_cnt = cnt_r;

endmodule
